// File: rtl/key_judge_if.sv
// -----------------------------------------------------------------------------
// key_judge_if
//
// Purpose : groups the game-side signals of key_judge into one bundle.
//
// Signals :
//   start               game start request (level)
//   key_in              raw push buttons, active-low, asynchronous
//   tile_lane           one-hot expected lane for the upcoming beat, 0 = rest
//   game_clock          beat clock, held 0 outside a running game
//   correct_key_pressed hit result of the current beat
//   miss                one-cycle pulse per missed beat
//   lives_left          remaining misses before game over
//   running             a game is in progress
//   game_over           game has ended
//
// Modports:
//   master  drives start/key_in/tile_lane, observes the results
//   slave   the judge itself
// -----------------------------------------------------------------------------
interface key_judge_if #(
    parameter int LANES = 4
);
    logic             start;
    logic [LANES-1:0] key_in;
    logic [LANES-1:0] tile_lane;
    logic             game_clock;
    logic             correct_key_pressed;
    logic             miss;
    logic [1:0]       lives_left;
    logic             running;
    logic             game_over;

    modport master (
        output start, key_in, tile_lane,
        input  game_clock, correct_key_pressed, miss, lives_left, running, game_over
    );

    modport slave (
        input  start, key_in, tile_lane,
        output game_clock, correct_key_pressed, miss, lives_left, running, game_over
    );
endinterface

// File: rtl/key_judge.sv
// -----------------------------------------------------------------------------
// key_judge
//
// Purpose : divides CLOCK_50 into the beat clock (game_clock) and judges the
//           player's key presses against the expected tile lane of each beat.
//           correct_key_pressed is held stable around the falling edge of
//           game_clock, where the downstream score counter samples it. Misses
//           are counted; when the lives run out the game ends and the beat
//           clock freezes low.
//
// Ports   :
//   CLOCK_50  in   sole clock, rising edge
//   reset     in   synchronous, active-low
//   bus       key_judge_if.slave (start, key_in, tile_lane in;
//             game_clock, correct_key_pressed, miss, lives_left, running,
//             game_over out)
//
// Parameters:
//   LANES            number of key lanes
//   BEAT_DIV         CLOCK_50 cycles per beat (even, >= 8)
//   MISS_LIMIT       misses allowed per game (1..3)
//   DEBOUNCE_CYCLES  stable cycles required per key (debounce build only)
//
// Build option:
//   KEY_DEBOUNCE_EN  when defined, each synchronised key must hold a new value
//                    for DEBOUNCE_CYCLES cycles before it is accepted.
//
// Beat timing (HALF = BEAT_DIV/2):
//   phase 0         expected lane latched, judgement state cleared
//   0 .. HALF-2     judgement window
//   HALF-1          decision cycle: result and miss pulse become visible
//   HALF            game_clock falls, score counter samples the result
// -----------------------------------------------------------------------------
module key_judge #(
    parameter int LANES           = 4,
    parameter int BEAT_DIV        = 25_000_000,
    parameter int MISS_LIMIT      = 3,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    key_judge_if.slave  bus
);

    localparam int HALF = BEAT_DIV / 2;
    localparam int PH_W = $clog2(BEAT_DIV);

    localparam logic [PH_W-1:0] PH_ZERO    = PH_W'(0);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(BEAT_DIV - 1);
    localparam logic [PH_W-1:0] PH_WIN_END = PH_W'(HALF - 2);
    localparam logic [PH_W-1:0] PH_DECIDE  = PH_W'(HALF - 1);
    localparam logic [PH_W-1:0] PH_HALF    = PH_W'(HALF);
    localparam logic [1:0]      LIVES_INIT = 2'(MISS_LIMIT);

    localparam bit CFG_OK = (BEAT_DIV % 2 == 0) && (BEAT_DIV >= 8) &&
                            (MISS_LIMIT >= 1) && (MISS_LIMIT <= 3) &&
                            (DEBOUNCE_CYCLES >= 1) && (LANES >= 1);

    if (!CFG_OK) begin : g_bad_cfg
        $error("key_judge: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OVER
    } state_t;

    // Lives never wrap below zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Key stage p0/p1: invert to active-high and synchronise.
    // -------------------------------------------------------------------------
    logic [LANES-1:0] key_s_p0;
    logic [LANES-1:0] key_s_p1;
    logic [LANES-1:0] key_cond;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            key_s_p0 <= '0;
            key_s_p1 <= '0;
        end else begin
            key_s_p0 <= ~bus.key_in;
            key_s_p1 <= key_s_p0;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    // -------------------------------------------------------------------------
    // Debounce: a lane's conditioned bit follows the synchroniser only after
    // the new value has been seen for DEBOUNCE_CYCLES consecutive cycles.
    // Any return to the old value restarts the count.
    // -------------------------------------------------------------------------
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt [LANES];

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            key_cond <= '0;
            for (int i = 0; i < LANES; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (key_s_p1[i] == key_cond[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_cond[i] <= key_s_p1[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end
`else
    assign key_cond = key_s_p1;
`endif

    // -------------------------------------------------------------------------
    // Key stage p2: registered rising-edge detect gives one press event per
    // lane. A key already held when a window opens has no edge left to report.
    // -------------------------------------------------------------------------
    logic [LANES-1:0] key_cond_d_p2;
    logic [LANES-1:0] key_evt_p2;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            key_cond_d_p2 <= '0;
            key_evt_p2    <= '0;
        end else begin
            key_cond_d_p2 <= key_cond;
            key_evt_p2    <= key_cond & ~key_cond_d_p2;
        end
    end

    // -------------------------------------------------------------------------
    // Judgement and beat control
    // -------------------------------------------------------------------------
    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [LANES-1:0] expected;
    logic             decided;
    logic             hit;
    logic             game_clock_q;
    logic             ckp_q;
    logic             miss_q;
    logic [1:0]       lives_q;
    logic             running_q;
    logic             over_q;

    logic [PH_W-1:0]  phase_nxt;
    logic             decided_n;
    logic             hit_n;
    logic             miss_now;

    // The first non-empty event set inside the window settles the beat; the
    // decision on the last window cycle must see that cycle's events, so the
    // updated flags are formed combinationally here.
    always_comb begin
        phase_nxt = (phase == PH_LAST) ? PH_ZERO : phase + PH_W'(1);
        decided_n = decided;
        hit_n     = hit;
        if (state == ST_RUN && phase <= PH_WIN_END && !decided && |key_evt_p2) begin
            decided_n = 1'b1;
            hit_n     = (key_evt_p2 == expected) && |expected;
        end
        miss_now = (decided_n && !hit_n) || (!decided_n && |expected);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state        <= ST_IDLE;
            phase        <= PH_ZERO;
            expected     <= '0;
            decided      <= 1'b0;
            hit          <= 1'b0;
            game_clock_q <= 1'b0;
            ckp_q        <= 1'b0;
            miss_q       <= 1'b0;
            lives_q      <= LIVES_INIT;
            running_q    <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        // The start edge is also the edge that sets phase 0.
                        state        <= ST_RUN;
                        running_q    <= 1'b1;
                        over_q       <= 1'b0;
                        phase        <= PH_ZERO;
                        game_clock_q <= 1'b1;
                        lives_q      <= LIVES_INIT;
                        expected     <= bus.tile_lane;
                        decided      <= 1'b0;
                        hit          <= 1'b0;
                        ckp_q        <= 1'b0;
                    end
                end

                ST_RUN: begin
                    phase        <= phase_nxt;
                    decided      <= decided_n;
                    hit          <= hit_n;
                    game_clock_q <= (phase_nxt < PH_HALF);

                    if (phase_nxt == PH_DECIDE) begin
                        ckp_q <= hit_n;
                        if (miss_now) begin
                            miss_q  <= 1'b1;
                            lives_q <= sat_dec(lives_q);
                        end
                    end

                    // Leaving the decision cycle with no lives: this beat's
                    // falling edge is the last one the score counter sees.
                    if (phase == PH_DECIDE && lives_q == 2'd0) begin
                        state        <= ST_OVER;
                        running_q    <= 1'b0;
                        over_q       <= 1'b1;
                        game_clock_q <= 1'b0;
                        ckp_q        <= 1'b0;
                    end

                    if (phase_nxt == PH_ZERO) begin
                        expected <= bus.tile_lane;
                        decided  <= 1'b0;
                        hit      <= 1'b0;
                        ckp_q    <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    running_q <= 1'b0;
                    over_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.game_clock          = game_clock_q;
    assign bus.correct_key_pressed = ckp_q;
    assign bus.miss                = miss_q;
    assign bus.lives_left          = lives_q;
    assign bus.running             = running_q;
    assign bus.game_over           = over_q;

endmodule

// File: tb/tb_key_judge.sv
// -----------------------------------------------------------------------------
// tb_key_judge
//
// Self-checking bench for key_judge with BEAT_DIV=8 (HALF=4, window phases
// 0..2, decision at phase 3), MISS_LIMIT=3, DEBOUNCE_CYCLES=2. Each beat's
// expected decision is queued when its stimulus is driven and compared when
// the DUT reaches the decision cycle.
// -----------------------------------------------------------------------------
module tb_key_judge;

    localparam int LANES      = 4;
    localparam int BEAT_DIV   = 8;
    localparam int MISS_LIMIT = 3;
    localparam int DEB        = 2;
`ifdef KEY_DEBOUNCE_EN
    localparam int LEAD    = 3 + DEB;
    localparam int KEY_LEN = DEB + 1;
`else
    localparam int LEAD    = 3;
    localparam int KEY_LEN = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_judge_if #(.LANES(LANES)) bus();

    key_judge #(
        .LANES(LANES),
        .BEAT_DIV(BEAT_DIV),
        .MISS_LIMIT(MISS_LIMIT),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic       ckp;
        logic       miss;
        logic [1:0] lives;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   ph       = 0;
    bit   run_m    = 1'b0;
    int   lives_m  = MISS_LIMIT;
    int   rel[LANES];

    // One clock; tracks the DUT phase and releases keys whose hold time ran out.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            run_m = 1'b0;
            ph    = 0;
        end else if (!run_m) begin
            if (bus.start) begin
                run_m = 1'b1;
                ph    = 0;
            end
        end else begin
            ph = (ph + 1) % BEAT_DIV;
        end
        #1;
        for (int i = 0; i < LANES; i++) begin
            if (rel[i] > 0) begin
                rel[i]--;
                if (rel[i] == 0) bus.key_in[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (ph != p && n < 2 * BEAT_DIV) begin
            step();
            n++;
        end
        if (ph != p) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_phase: phase %0d never reached %0d", ph, p);
        end
    endtask

    task automatic press(input int lane, input int len);
        bus.key_in[lane] = 1'b0;
        rel[lane]        = len;
    endtask

    // Enters at the decision cycle of the previous beat, schedules the presses
    // so their events land on the requested phases of the next beat, queues
    // the expected decision and returns at that beat's decision cycle.
    task automatic play_beat(input logic [3:0] tile,
                             input int la, input int pa, input int lena,
                             input int lb, input int pb,
                             input logic e_ckp, input logic e_miss);
        exp_t e;
        wait_phase(3);
        bus.tile_lane = tile;
        if (e_miss && lives_m > 0) lives_m--;
        e.ckp   = e_ckp;
        e.miss  = e_miss;
        e.lives = 2'(lives_m);
        sb.push_back(e);
        for (int off = -5; off <= 2; off++) begin
            if (la >= 0 && off == pa - LEAD) press(la, lena);
            if (lb >= 0 && off == pb - LEAD) press(lb, KEY_LEN);
            step();
        end
        bus.tile_lane = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_checks++; if (bus.game_clock !== 1'b0) begin n_err++; $display("FAIL reset_gclk: got %b want 0", bus.game_clock); end
        n_checks++; if (bus.correct_key_pressed !== 1'b0) begin n_err++; $display("FAIL reset_ckp: got %b want 0", bus.correct_key_pressed); end
        n_checks++; if (bus.miss !== 1'b0) begin n_err++; $display("FAIL reset_miss: got %b want 0", bus.miss); end
        n_checks++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", bus.running); end
        n_checks++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL reset_over: got %b want 0", bus.game_over); end
        n_checks++; if (bus.lives_left !== 2'd3) begin n_err++; $display("FAIL reset_lives: got %0d want 3", bus.lives_left); end
        reset = 1'b1;
        step();
    endtask

    task automatic restart(input string tag);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lives_m   = MISS_LIMIT;
        n_checks++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL %s_running: got %b want 1", tag, bus.running); end
        n_checks++; if (bus.game_clock !== 1'b1) begin n_err++; $display("FAIL %s_gclk: got %b want 1", tag, bus.game_clock); end
        n_checks++; if (bus.lives_left !== 2'd3) begin n_err++; $display("FAIL %s_lives: got %0d want 3", tag, bus.lives_left); end
        n_checks++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL %s_over: got %b want 0", tag, bus.game_over); end
    endtask

    task automatic test_start_rest();
        exp_t e;
        bus.tile_lane = '0;
        restart("start");
        e.ckp = 1'b0; e.miss = 1'b0; e.lives = 2'(lives_m);
        sb.push_back(e);
        wait_phase(3);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL first_rest_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL first_rest_miss: got %b want %b", bus.miss, e.miss); end
        n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL first_rest_lives: got %0d want %0d", bus.lives_left, e.lives); end
    endtask

    task automatic test_hit();
        exp_t e;
        play_beat(4'b0010, 1, 1, KEY_LEN, -1, 0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL hit_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL hit_miss: got %b want %b", bus.miss, e.miss); end
        n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL hit_lives: got %0d want %0d", bus.lives_left, e.lives); end
        step();
        n_checks++; if (bus.game_clock !== 1'b0) begin n_err++; $display("FAIL hit_gclk_fall: got %b want 0", bus.game_clock); end
        n_checks++; if (bus.correct_key_pressed !== 1'b1) begin n_err++; $display("FAIL hit_ckp_ph4: got %b want 1", bus.correct_key_pressed); end
        wait_phase(7);
        n_checks++; if (bus.correct_key_pressed !== 1'b1) begin n_err++; $display("FAIL hit_ckp_ph7: got %b want 1", bus.correct_key_pressed); end
        step();
        n_checks++; if (bus.correct_key_pressed !== 1'b0) begin n_err++; $display("FAIL hit_ckp_clear: got %b want 0", bus.correct_key_pressed); end
        n_checks++; if (bus.game_clock !== 1'b1) begin n_err++; $display("FAIL hit_gclk_rise: got %b want 1", bus.game_clock); end
    endtask

    task automatic test_wrong_key();
        exp_t e;
        play_beat(4'b0001, 2, 0, KEY_LEN, 0, 1, 1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL wrong_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL wrong_miss: got %b want %b", bus.miss, e.miss); end
        n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL wrong_lives: got %0d want %0d", bus.lives_left, e.lives); end
        step();
        n_checks++; if (bus.miss !== 1'b0) begin n_err++; $display("FAIL wrong_miss_width: got %b want 0", bus.miss); end
    endtask

    task automatic test_late_press();
        exp_t e;
        play_beat(4'b1000, 3, 3, KEY_LEN, -1, 0, 1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL late_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL late_miss: got %b want %b", bus.miss, e.miss); end
        n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL late_lives: got %0d want %0d", bus.lives_left, e.lives); end
    endtask

    task automatic test_rest_beat();
        exp_t e;
        play_beat(4'b0000, -1, 0, KEY_LEN, -1, 0, 1'b0, 1'b0);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL rest_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL rest_miss: got %b want %b", bus.miss, e.miss); end
        n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL rest_lives: got %0d want %0d", bus.lives_left, e.lives); end
    endtask

    task automatic check_over(input string tag);
        bit bad = 1'b0;
        step();
        run_m = 1'b0;
        n_checks++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL %s_over: got %b want 1", tag, bus.game_over); end
        n_checks++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL %s_running: got %b want 0", tag, bus.running); end
        n_checks++; if (bus.game_clock !== 1'b0) begin n_err++; $display("FAIL %s_gclk: got %b want 0", tag, bus.game_clock); end
        n_checks++; if (bus.correct_key_pressed !== 1'b0) begin n_err++; $display("FAIL %s_ckp: got %b want 0", tag, bus.correct_key_pressed); end
        for (int i = 0; i < 2 * BEAT_DIV; i++) begin
            step();
            if (bus.game_clock !== 1'b0 || bus.game_over !== 1'b1) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_err++; $display("FAIL %s_frozen: gclk %b over %b, want gclk 0 over 1", tag, bus.game_clock, bus.game_over); end
    endtask

    task automatic test_game_over();
        exp_t e;
        play_beat(4'b0100, -1, 0, KEY_LEN, -1, 0, 1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL last_miss: got %b want %b", bus.miss, e.miss); end
        n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL last_lives: got %0d want %0d", bus.lives_left, e.lives); end
        check_over("over1");
        restart("restart1");
    endtask

    task automatic test_consecutive_misses();
        exp_t e;
        for (int b = 0; b < 3; b++) begin
            play_beat(4'b0001, -1, 0, KEY_LEN, -1, 0, 1'b0, 1'b1);
            e = sb.pop_front();
            n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL consec%0d_miss: got %b want %b", b, bus.miss, e.miss); end
            n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL consec%0d_lives: got %0d want %0d", b, bus.lives_left, e.lives); end
            n_checks++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL consec%0d_over: got %b want 0", b, bus.game_over); end
        end
        check_over("over2");
        restart("restart2");
    endtask

`ifdef KEY_DEBOUNCE_EN
    task automatic test_debounce();
        exp_t e;
        play_beat(4'b0001, 0, 1, 1, -1, 0, 1'b0, 1'b1);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL glitch_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL glitch_miss: got %b want %b", bus.miss, e.miss); end
        play_beat(4'b0001, 0, 2, KEY_LEN, -1, 0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL debounced_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        n_checks++; if (bus.miss !== e.miss) begin n_err++; $display("FAIL debounced_miss: got %b want %b", bus.miss, e.miss); end
        n_checks++; if (bus.lives_left !== e.lives) begin n_err++; $display("FAIL debounced_lives: got %0d want %0d", bus.lives_left, e.lives); end
    endtask
`endif

    task automatic test_reset_mid_beat();
        exp_t e;
        play_beat(4'b0010, 1, 1, KEY_LEN, -1, 0, 1'b1, 1'b0);
        e = sb.pop_front();
        n_checks++; if (bus.correct_key_pressed !== e.ckp) begin n_err++; $display("FAIL pre_reset_ckp: got %b want %b", bus.correct_key_pressed, e.ckp); end
        wait_phase(5);
        n_checks++; if (bus.correct_key_pressed !== 1'b1) begin n_err++; $display("FAIL pre_reset_ckp_ph5: got %b want 1", bus.correct_key_pressed); end
        reset     = 1'b0;
        bus.start = 1'b1;
        step();
        lives_m = MISS_LIMIT;
        n_checks++; if (bus.game_clock !== 1'b0) begin n_err++; $display("FAIL midrst_gclk: got %b want 0", bus.game_clock); end
        n_checks++; if (bus.correct_key_pressed !== 1'b0) begin n_err++; $display("FAIL midrst_ckp: got %b want 0", bus.correct_key_pressed); end
        n_checks++; if (bus.miss !== 1'b0) begin n_err++; $display("FAIL midrst_miss: got %b want 0", bus.miss); end
        n_checks++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL midrst_running: got %b want 0", bus.running); end
        n_checks++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL midrst_over: got %b want 0", bus.game_over); end
        n_checks++; if (bus.lives_left !== 2'd3) begin n_err++; $display("FAIL midrst_lives: got %0d want 3", bus.lives_left); end
        step();
        n_checks++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL midrst_start_ignored: got %b want 0", bus.running); end
        reset     = 1'b1;
        bus.start = 1'b0;
        step();
        n_checks++; if (bus.running !== 1'b0 || bus.game_clock !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: running %b gclk %b want 0 0", bus.running, bus.game_clock); end
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.key_in    = '1;
        bus.tile_lane = '0;
        for (int i = 0; i < LANES; i++) rel[i] = 0;
        @(negedge clk);

        test_reset();
        test_start_rest();
        test_hit();
        test_wrong_key();
        test_late_press();
        test_rest_beat();
        test_game_over();
        test_consecutive_misses();
`ifdef KEY_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid_beat();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1);
    end

endmodule
